// File: rtl/read_rc4_if.sv
// Request, memory-read and output-stream signals of the read_rc4 burst reader.
// The reader itself connects through the slave modport; its driver uses master.
interface read_rc4_if;
  logic       start;
  logic [3:0] base_addr;
  logic [4:0] len;
  logic       abort;
  logic       rd_1;
  logic [3:0] addo;
  logic [3:0] mem_data;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;

  modport slave (
    input  start, base_addr, len, abort, mem_data, out_ready,
    output rd_1, addo, out_data, out_valid, busy, done
  );

  modport master (
    output start, base_addr, len, abort, mem_data, out_ready,
    input  rd_1, addo, out_data, out_valid, busy, done
  );
endinterface

// File: rtl/read_rc4.sv
// Burst reader: issues up to 16 nibble reads from a wrapping 4-bit address space
// and streams the returned data through a 2-entry FIFO with valid/ready flow control.
module read_rc4 (
  input  logic      clk,
  input  logic      rst,
  read_rc4_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] base_q;
  logic [4:0] len_q;
  logic [4:0] issued;
  logic       inflight;
  logic       done_q;

  logic [3:0] fifo_mem [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] count;

  logic [4:0] len_clamped;
  logic       pop;
  logic       rd;
  logic       last_transfer;
  logic       flush;
  logic [2:0] occupancy;

  // A read may issue only if the FIFO can still hold its data after this
  // cycle's pop, counting the read already on its way back from memory.
  always_comb begin
    len_clamped   = (bus.len > 5'd16) ? 5'd16 : bus.len;
    pop           = (count != 2'd0) && bus.out_ready;
    occupancy     = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    rd            = !rst && (state == RUN) && !bus.abort &&
                    (issued < len_q) && (occupancy < 3'd2);
    last_transfer = (state == DRAIN) && pop && (count == 2'd1) && !inflight;
    flush         = bus.abort && (state != IDLE);
  end

  assign bus.rd_1      = rd;
  assign bus.addo      = rd ? (base_q + issued[3:0]) : 4'h0;
  assign bus.out_valid = (count != 2'd0);
  assign bus.out_data  = fifo_mem[rd_ptr];
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      base_q   <= 4'h0;
      len_q    <= 5'd0;
      issued   <= 5'd0;
      inflight <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      inflight <= rd;
      case (state)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            base_q <= bus.base_addr;
            len_q  <= len_clamped;
            issued <= 5'd0;
            if (len_clamped == 5'd0) begin
              done_q <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (bus.abort) begin
            state <= IDLE;
          end else if (rd) begin
            issued <= issued + 5'd1;
            if (issued + 5'd1 == len_q) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (bus.abort) begin
            state <= IDLE;
          end else if (last_transfer) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Returned data lands one cycle after its read; an abort drops both the
  // buffered nibbles and the one still in flight (inflight is zero next cycle).
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_mem[0] <= 4'h0;
      fifo_mem[1] <= 4'h0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      count       <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (inflight) begin
        fifo_mem[wr_ptr] <= bus.mem_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({inflight, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_read_rc4.sv
// Directed bench for read_rc4: memory model returns addr k as data k one cycle
// after each read; inputs change 1 time unit after posedge, outputs sampled at negedge.
module tb_read_rc4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  read_rc4_if bus ();

  read_rc4 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.rd_1) bus.mem_data <= bus.addo;
    else          bus.mem_data <= 4'hC;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [11:0] obs;
    rst = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.base_addr = 4'h0; bus.len = 5'd0;
    bus.out_ready = 1'b1; bus.mem_data = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    obs = {bus.rd_1, bus.addo, bus.out_valid, bus.out_data, bus.busy, bus.done};
    checks++;
    if (obs !== 12'h000) begin
      errors++;
      $display("[TB] FAIL reset_state got=%h exp=000", obs);
    end
    next_cycle();
    rst = 1'b0;
    bus.abort = 1'b1;
    @(negedge clk);
    obs = {bus.rd_1, bus.addo, bus.out_valid, bus.out_data, bus.busy, bus.done};
    checks++;
    if (obs !== 12'h000) begin
      errors++;
      $display("[TB] FAIL abort_in_idle got=%h exp=000", obs);
    end
    next_cycle();
    bus.abort = 1'b0;
  endtask

  // Start in cycle 0; start stays high with a different base while busy and must be ignored.
  task automatic test_burst(input logic [3:0] b, input logic [4:0] lin, input int el);
    logic [11:0] obs;
    logic [11:0] exp;
    logic        e_rd, e_ov;
    logic [3:0]  e_addo, e_od;
    for (int c = 0; c <= el + 4; c++) begin
      bus.start     = (c <= el + 2);
      bus.base_addr = (c == 0) ? b : ~b;
      bus.len       = lin;
      bus.out_ready = 1'b1;
      @(negedge clk);
      e_rd   = (c >= 1) && (c <= el);
      e_addo = e_rd ? 4'(int'(b) + c - 1) : 4'h0;
      e_ov   = (c >= 3) && (c <= el + 2);
      e_od   = e_ov ? 4'(int'(b) + c - 3) : 4'h0;
      exp = {e_rd, e_addo, e_ov, e_od, (c >= 1) && (c <= el + 2), (c == el + 3)};
      obs = {bus.rd_1, bus.rd_1 ? bus.addo : 4'h0, bus.out_valid,
             bus.out_valid ? bus.out_data : 4'h0, bus.busy, bus.done};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL burst b=%0d len=%0d cycle=%0d got=%h exp=%h", b, lin, c, obs, exp);
      end
      next_cycle();
    end
    bus.start = 1'b0;
  endtask

  task automatic test_len_zero();
    logic [2:0] obs;
    bus.start = 1'b1; bus.base_addr = 4'h5; bus.len = 5'd0;
    for (int c = 0; c <= 2; c++) begin
      @(negedge clk);
      obs = {bus.rd_1, bus.busy, bus.done};
      checks++;
      if (obs !== {2'b00, c == 1}) begin
        errors++;
        $display("[TB] FAIL len_zero cycle=%0d got=%b exp=%b", c, obs, {2'b00, c == 1});
      end
      next_cycle();
      bus.start = 1'b0;
    end
    bus.start = 1'b1; bus.abort = 1'b1; bus.len = 5'd3;
    next_cycle();
    bus.start = 1'b0; bus.abort = 1'b0;
    for (int c = 0; c <= 1; c++) begin
      @(negedge clk);
      obs = {bus.rd_1, bus.busy, bus.done};
      checks++;
      if (obs !== 3'b000) begin
        errors++;
        $display("[TB] FAIL start_with_abort cycle=%0d got=%b exp=000", c, obs);
      end
      next_cycle();
    end
  endtask

  task automatic test_stall();
    int reads = 0;
    int nib   = 0;
    int dones = 0;
    for (int c = 0; c <= 35; c++) begin
      bus.start = (c == 0); bus.base_addr = 4'h0; bus.len = 5'd16;
      bus.out_ready = !((c >= 4) && (c <= 9));
      @(negedge clk);
      if ((c >= 4) && (c <= 9)) begin
        checks++;
        if ({bus.rd_1, bus.out_valid, bus.out_data} !== 6'b01_0001) begin
          errors++;
          $display("[TB] FAIL stall_hold cycle=%0d got=%b exp=010001", c,
                   {bus.rd_1, bus.out_valid, bus.out_data});
        end
      end
      if (c == 10) begin
        checks++;
        if ({bus.rd_1, bus.addo} !== 5'h13) begin
          errors++;
          $display("[TB] FAIL stall_resume got=%h exp=13", {bus.rd_1, bus.addo});
        end
      end
      if (bus.rd_1) begin
        checks++;
        if (bus.addo !== 4'(reads)) begin
          errors++;
          $display("[TB] FAIL stall_addr got=%0d exp=%0d", bus.addo, reads);
        end
        reads++;
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (bus.out_data !== 4'(nib)) begin
          errors++;
          $display("[TB] FAIL stall_data got=%0d exp=%0d", bus.out_data, nib);
        end
        nib++;
      end
      if (bus.done) dones++;
      next_cycle();
    end
    bus.out_ready = 1'b1;
    checks++;
    if ({reads, nib, dones} !== {32'd16, 32'd16, 32'd1}) begin
      errors++;
      $display("[TB] FAIL stall_totals got reads=%0d nibbles=%0d dones=%0d exp 16/16/1",
               reads, nib, dones);
    end
  endtask

  task automatic test_abort();
    for (int c = 0; c <= 5; c++) begin
      bus.start = (c == 0); bus.base_addr = 4'h5; bus.len = 5'd8;
      bus.abort = (c == 4); bus.out_ready = 1'b1;
      @(negedge clk);
      if ((c >= 1) && (c <= 3)) begin
        checks++;
        if ({bus.rd_1, bus.addo} !== {1'b1, 4'(4 + c)}) begin
          errors++;
          $display("[TB] FAIL abort_pre cycle=%0d got=%h exp=%h", c,
                   {bus.rd_1, bus.addo}, {1'b1, 4'(4 + c)});
        end
      end
      if (c == 4) begin
        checks++;
        if ({bus.rd_1, bus.done} !== 2'b00) begin
          errors++;
          $display("[TB] FAIL abort_cycle got=%b exp=00", {bus.rd_1, bus.done});
        end
      end
      if (c == 5) begin
        checks++;
        if ({bus.rd_1, bus.out_valid, bus.busy, bus.done} !== 4'b0000) begin
          errors++;
          $display("[TB] FAIL abort_after got=%b exp=0000",
                   {bus.rd_1, bus.out_valid, bus.busy, bus.done});
        end
      end
      next_cycle();
    end
    bus.abort = 1'b0;
    test_burst(4'd9, 5'd2, 2);
  endtask

  task automatic test_reset_mid();
    logic [11:0] obs;
    for (int c = 0; c <= 6; c++) begin
      bus.start = (c == 0); bus.base_addr = 4'h2; bus.len = 5'd8;
      bus.out_ready = 1'b1;
      rst = (c == 3);
      @(negedge clk);
      if (c >= 4) begin
        obs = {bus.rd_1, bus.addo, bus.out_valid, bus.out_data, bus.busy, bus.done};
        checks++;
        if (obs !== 12'h000) begin
          errors++;
          $display("[TB] FAIL reset_mid cycle=%0d got=%h exp=000", c, obs);
        end
      end
      next_cycle();
    end
    rst = 1'b0;
    bus.start = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_burst(4'd3, 5'd4, 4);
    test_burst(4'd14, 5'd5, 5);
    test_len_zero();
    test_burst(4'd7, 5'd20, 16);
    test_stall();
    test_abort();
    test_reset_mid();
    test_burst(4'd0, 5'd4, 4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/read_rc4.md
READ_RC4 -- requirements
Module: read_rc4

Interface
REQ-001 clk  input  1  single clock; all state updates on posedge clk.
REQ-002 rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-003 start  input  1  burst request; sampled only in IDLE.
REQ-004 base_addr  input  4  first memory address of burst; captured with start.
REQ-005 len  input  5  burst length in nibbles, 0..16; values >16 clamp to 16; captured with start.
REQ-006 abort  input  1  terminates an active burst.
REQ-007 rd_1  output  1  memory read strobe; one read per cycle asserted.
REQ-008 addo  output  4  memory read address; meaningful only while rd_1=1.
REQ-009 mem_data  input  4  memory read data; valid exactly one cycle after the cycle rd_1=1.
REQ-010 out_data  output  4  streamed nibble; head of output FIFO.
REQ-011 out_valid  output  1  out_data valid.
REQ-012 out_ready  input  1  consumer accepts; transfer = out_valid && out_ready.
REQ-013 busy  output  1  high in RUN and DRAIN.
REQ-014 done  output  1  one-cycle pulse on completion of a non-aborted burst.

Function
REQ-015 FSM states IDLE, RUN, DRAIN; IDLE after reset.
REQ-016 IDLE: start=1 and abort=0 -> capture base_addr, clamped len; go RUN; len=0 -> stay IDLE, pulse done next cycle, no reads.
REQ-017 start while busy shall be ignored; start with abort in IDLE shall be ignored.
REQ-018 RUN: issue counter i from 0; addo = (base_addr + i) mod 16 (wrap 15 -> 0); i increments on each rd_1.
REQ-019 rd_1 = RUN and issued < len and (fifo_count + inflight - pop) < 2, where inflight = rd_1 of previous cycle, pop = transfer this cycle.
REQ-020 Output FIFO depth 2, nibble wide; mem_data pushed in the cycle after its rd_1; FIFO never overflows; returned data never dropped except on abort/reset.
REQ-021 out_valid = fifo_count > 0, registered state only; out_data stable while out_valid=1 and out_ready=0.
REQ-022 Latency: start sampled in cycle 0 -> rd_1 in cycle 1 -> push in cycle 2 -> out_valid in cycle 3.
REQ-023 out_ready held high: one nibble per cycle sustained, no bubbles after first.
REQ-024 RUN -> DRAIN when last read issued; DRAIN -> IDLE on transfer of final nibble; done=1 in the cycle after that transfer.
REQ-025 Simultaneous push and pop: count unchanged, order preserved (FIFO order = address order).
REQ-026 abort=1 in RUN/DRAIN: no further rd_1 from that cycle; FIFO flushed and in-flight return discarded; out_valid=0 next cycle; IDLE next cycle; no done.
REQ-027 abort in IDLE: no effect.
REQ-028 Block never drives memory write; rd_1 never asserted in IDLE.

Reset
REQ-029 rst=1: state IDLE, rd_1=0, addo=0, out_valid=0, out_data=0, busy=0, done=0, FIFO empty, counters 0, inflight cleared.
REQ-030 rst mid-burst shall take effect on the same edge; in-flight mem_data next cycle discarded.
REQ-031 rst has priority over start and abort.

Verification
REQ-032 Memory preloaded addr k = k; base_addr=3, len=4, out_ready=1 -> addo 3,4,5,6 cycles 1-4; out_data 3,4,5,6 cycles 3-6; done in cycle 7.
REQ-033 base_addr=14, len=5 -> addresses 14,15,0,1,2; out_data 14,15,0,1,2.
REQ-034 base_addr=0, len=16, out_ready low cycles 4-9 -> rd_1 stalls while FIFO+inflight = 2, no loss or duplication, 0..15 in order, done once.
REQ-035 len=0 -> no rd_1, busy stays 0, done pulse one cycle after start; len=20 -> exactly 16 nibbles.
REQ-036 abort in cycle 4 of a len=8 burst -> rd_1=0 from cycle 4, out_valid=0 cycle 5, no done; new start in cycle 6 runs cleanly.
REQ-037 rst asserted in cycle 3 of a burst -> all outputs reset values next cycle; stray mem_data ignored.
